mips_multicycle_core: RTL
=========================

# mips_multicycle_core

Multi-cycle MIPS-subset processor core. It executes one instruction over 3–5 states of a control FSM and reaches instruction and data through a single shared memory port with a req/ready handshake, so it tolerates variable-latency memory. It is the parametrised successor to the team's single-cycle OR/SUBI/SW/BEQ core: wider instruction set, configurable reset vector and address width, wait-state tolerance, and a halt mode.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ADDR_W, 32, width of mem_addr (2..32); byte address, the PC is truncated to ADDR_W.
- HALT_ON_ILLEGAL, 1, 1 = illegal opcode/funct enters HALT; 0 = treated as NOP.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_req  out  1  memory transaction request.
- mem_we  out  1  1 = write (SW), 0 = read (fetch/LW).
- mem_addr  out  ADDR_W  byte address; word-aligned for all legal traffic.
- mem_wdata  out  32  store data.
- mem_rdata  in  32  read data, valid in the cycle mem_ready=1.
- mem_ready  in  1  transaction completes in any cycle with mem_req & mem_ready.
- pc_out  out  32  architectural PC of the instruction in flight.
- retire  out  1  one-cycle pulse in the final state of each completed instruction.
- halt  out  1  sticky; core stopped.

## Operation
- Register file: 32 x 32 internal array `register`; r0 reads 0 and writes to it are discarded; all registers clear on reset.
- R-type (opcode 0x00), selected by funct: ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2A (signed). rd <= result.
- I-type: ADDI 0x08, SUBI 0x1C (rt <= rs − sext(imm)), ORI 0x0D (zero-extended imm), LW 0x23, SW 0x2B (address = rs + sext(imm)), BEQ 0x04, BNE 0x05.
- J 0x02: PC <= {PC+4[31:28], target, 2'b00}.
- Branch target = PC + 4 + (sext(imm) << 2); all arithmetic is 32-bit modulo 2^32, with no overflow traps.
- FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
  - FETCH: mem_req=1, mem_we=0, mem_addr=PC. On ready, latch IR and go to DECODE.
  - DECODE: read rs/rt into A/B; compute PC+4 and the branch target.
    - J: PC <= target, retire, go to FETCH.
    - Illegal: go to HALT (or act as NOP, per HALT_ON_ILLEGAL).
    - Otherwise go to EXEC.
  - EXEC: compute the ALU result into ALUOut.
    - BEQ/BNE: PC <= taken ? target : PC+4, retire, go to FETCH.
    - LW/SW: go to MEM.
    - Otherwise go to WB.
  - MEM: mem_req=1, mem_addr=ALUOut, mem_we=(SW), mem_wdata=B. Hold until ready.
    - SW: PC <= PC+4, retire, go to FETCH.
    - LW: latch MDR, go to WB.
  - WB: write rd/rt (ALUOut or MDR); PC <= PC+4; retire; go to FETCH.
  - HALT: absorbing state with mem_req=0 and halt=1; only reset leaves it.
- A misaligned LW/SW address is driven unmodified; memory ignores addr[1:0].

## Timing
- Reset values:
  - pc_out = RESET_PC
  - mem_req = 0, mem_we = 0, mem_addr = RESET_PC[ADDR_W-1:0], mem_wdata = 0
  - retire = 0, halt = 0
  - state = FETCH, all registers = 0
- mem_req asserts in the first clk edge after rst deasserts.
- Handshake:
  - mem_addr, mem_we and mem_wdata are stable while mem_req=1 and ready=0.
  - mem_req deasserts in the cycle after the completing (req & ready) cycle.
  - Every wait cycle adds exactly one cycle to the instruction.
- Latency with zero wait states (ready=1 whenever req=1):
  - J: 2 cycles
  - BEQ/BNE: 3 cycles
  - R-type/ADDI/SUBI/ORI: 4 cycles
  - SW: 4 cycles
  - LW: 5 cycles
- Register-file writes and PC updates commit at the clk edge ending the retiring state; retire is high during that state.
- Reset asserted mid-transaction: all outputs return to reset values immediately (asynchronously). A pending SW is abandoned; memory must ignore it because req falls.

## Test plan
- Preload r1=0xFF, r2=0xF00, r5=80, r6=0xDEADBEEF, r7=0x10, r8=r9=0x12345678. Run OR r3,r1,r2; SUBI r4,r5,21; SW r6,5(r7); BEQ r9,r8,7 with zero wait states.
  - Required: r3=0x0FFF, r4=0x3B, mem word 5 = 0xDEADBEEF, PC=0x2C.
  - Retire pulses at cycles 4, 8, 12, 15 after reset release.
- Same program with mem_ready held low 2 cycles per transaction.
  - Required: identical results, each instruction +2 cycles per memory access.
  - Address, we and wdata are stable throughout each wait.
- LW r10,4(r7) with mem word 5 = 0xCAFEF00D, then BNE r10,r0,−1.
  - Required: r10=0xCAFEF00D after 5 cycles.
  - BNE is taken and loops back to its own PC.
- ADDI r0,r1,5, then SLT r11,r12,r13 with r12=−1 and r13=1.
  - Required: r0 stays 0, r11=1.
- Illegal opcode 0x3F with HALT_ON_ILLEGAL=1.
  - Required: halt=1 in the cycle after DECODE; mem_req stays 0 forever.
  - PC holds the illegal instruction's address.
- Assert rst during a waiting SW (req=1, ready=0).
  - Required: mem_req falls within the same cycle, memory is unchanged, PC=RESET_PC.
  - After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS-subset core: a single req/ready memory port shared by fetch and
// load/store, driven by a FETCH/DECODE/EXEC/MEM/WB control FSM with a sticky HALT state.
module mips_multicycle_core #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned ADDR_W          = 32,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       pc_out,
  output logic              retire,
  output logic              halt
);
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J   = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08, OP_ORI = 6'h0D, OP_SUBI = 6'h1C;
  localparam logic [5:0] OP_LW    = 6'h23, OP_SW  = 6'h2B;
  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
  logic [31:0] alu_q, alu_d, mdr_q, mdr_d;
  logic        run_q;
  logic [31:0] register [32];

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, rf_waddr;
  logic [31:0] simm, zimm, pc_plus4, br_target, j_target, alu_res, addr_full, rf_wdata;
  logic        legal, is_branch, taken, is_mem, rf_we;

  assign op        = ir_q[31:26];
  assign rs        = ir_q[25:21];
  assign rt        = ir_q[20:16];
  assign rd        = ir_q[15:11];
  assign funct     = ir_q[5:0];
  assign simm      = {{16{ir_q[15]}}, ir_q[15:0]};
  assign zimm      = {16'h0000, ir_q[15:0]};
  assign pc_plus4  = pc_q + 32'd4;
  assign br_target = pc_plus4 + (simm << 2);
  assign j_target  = {pc_plus4[31:28], ir_q[25:0], 2'b00};
  assign is_branch = (op == OP_BEQ) || (op == OP_BNE);
  assign taken     = (op == OP_BEQ) ? (a_q == b_q) : (a_q != b_q);
  assign is_mem    = (op == OP_LW) || (op == OP_SW);

  assign pc_out    = pc_q;
  assign mem_wdata = b_q;
  assign mem_addr  = addr_full[ADDR_W-1:0];

  always_comb begin
    legal = 1'b0;
    case (op)
      OP_RTYPE: legal = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                        (funct == FN_OR)  || (funct == FN_SLT);
      OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_SUBI, OP_LW, OP_SW: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  alu_res = a_q + b_q;
          FN_SUB:  alu_res = a_q - b_q;
          FN_AND:  alu_res = a_q & b_q;
          FN_OR:   alu_res = a_q | b_q;
          FN_SLT:  alu_res = {31'b0, $signed(a_q) < $signed(b_q)};
          default: alu_res = '0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: alu_res = a_q + simm;
      OP_SUBI:               alu_res = a_q - simm;
      OP_ORI:                alu_res = a_q | zimm;
      default:               alu_res = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    alu_d     = alu_q;
    mdr_d     = mdr_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_full = pc_q;
    retire    = 1'b0;
    halt      = 1'b0;
    rf_we     = 1'b0;
    rf_waddr  = rt;
    rf_wdata  = alu_q;
    case (state_q)
      S_FETCH: begin
        // run_q keeps the first request off until one edge after reset release
        mem_req = run_q;
        if (run_q && mem_ready) begin
          ir_d    = mem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d = register[rs];
        b_d = register[rt];
        if (op == OP_J) begin
          pc_d    = j_target;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (!legal) begin
          if (HALT_ON_ILLEGAL) begin
            state_d = S_HALT;
          end else begin
            pc_d    = pc_plus4;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_d = alu_res;
        if (is_branch) begin
          pc_d    = taken ? br_target : pc_plus4;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (is_mem) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_req   = 1'b1;
        mem_we    = (op == OP_SW);
        addr_full = alu_q;
        if (mem_ready) begin
          if (op == OP_SW) begin
            pc_d    = pc_plus4;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            mdr_d   = mem_rdata;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we    = 1'b1;
        rf_waddr = (op == OP_RTYPE) ? rd : rt;
        rf_wdata = (op == OP_LW) ? mdr_q : alu_q;
        pc_d     = pc_plus4;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      default: halt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
      run_q   <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 32; i++) register[i] <= '0;
    end else if (rf_we && (rf_waddr != 5'd0)) begin
      register[rf_waddr] <= rf_wdata;
    end
  end
endmodule
